// File: rtl/start_sequencer.sv
// start_sequencer: queues job requests and launches them one at a time
// into a downstream counter FSM, waiting for its done pulse between jobs.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req_valid    - job request offered; req_ready - request can be taken
//   start        - one-cycle launch pulse; done - completion pulse back
//   err_clr      - clears the sticky timeout flag
//   busy         - FSM not idle; pending - queued, not-yet-launched jobs
//   done_cnt     - completed jobs (wraps); timeout_err - sticky abort flag
//
// Build option: define START_SEQ_TIMEOUT_EN to enable the WAIT watchdog.
// Without it WAIT lasts until done and timeout_err is tied low.
module start_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       start,
  input  logic       done,
  input  logic       err_clr,
  output logic       busy,
  output logic [3:0] pending,
  output logic [7:0] done_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic accept;
  logic issue;
  logic fire;
  logic tmo;

  assign req_ready = (pending < 4'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign issue     = (state == ISSUE);
  assign fire      = (state == WAIT) & done;

`ifdef START_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Fires in the WAIT cycle whose increment would bring the
  // counter to TIMEOUT, so WAIT lasts exactly TIMEOUT cycles.
  assign tmo = (state == WAIT) & ~done &
               ((9'(wd_cnt) + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= 8'd0;
    end else if (issue) begin
      wd_cnt <= 8'd0;
    end else if ((state == WAIT) && !done) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // A timeout in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign tmo            = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pending != 4'd0) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (fire || tmo) begin
          state_nx = COOL;
        end
      end
      COOL: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    start = 1'b0;
    busy  = 1'b1;
    unique case (1'b1)
      (state == IDLE):  busy  = 1'b0;
      (state == ISSUE): start = 1'b1;
      default: ;
    endcase
  end

  // ISSUE is only entered with pending > 0 and pending cannot drop
  // before the decrement, so the count never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 4'd0;
    end else begin
      unique case ({accept, issue})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= 8'd0;
    end else if (fire) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: self-checking bench for start_sequencer.
// Table vectors, directed corner sequences and a random run vs a model.
module tb_start_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       start;
  logic       done = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic [3:0] pending;
  logic [7:0] done_cnt;
  logic       timeout_err;

  always #5 clk = ~clk;

  start_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .start       (start),
    .done        (done),
    .err_clr     (err_clr),
    .busy        (busy),
    .pending     (pending),
    .done_cnt    (done_cnt),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Job-timeline model: queue length, age of the in-flight job
  // (-1 none, 0 launch cycle, n = n-th cycle awaiting done),
  // one-cycle cool-down flag, total completions, sticky error.
  int m_q   = 0;
  int m_age = -1;
  int m_tot = 0;
  bit m_cool = 0;
  bit m_err  = 0;
  bit last_acc;

  typedef struct {
    bit v;
    bit d;
    bit c;
    bit r;
    int p;
    bit s;
    bit b;
    int dc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic step(bit v, bit d, bit c, bit r);
    int nq;
    int nage;
    int ntot;
    bit ncool;
    bit nerr;
    bit acc;
    bit tmo;
    req_valid = v;
    done      = d;
    err_clr   = c;
    rst       = r;
    #1;
    last_acc = v && req_ready;
    acc = v && (m_q < DEPTH);
    tmo = 0;
    if (r) begin
      nq = 0; nage = -1; ncool = 0; ntot = 0; nerr = 0;
    end else begin
      nq    = m_q + (acc ? 1 : 0) - ((m_age == 0) ? 1 : 0);
      ntot  = m_tot;
      nerr  = m_err;
      ncool = 0;
      nage  = m_age;
      if (m_cool) nage = -1;
      else if (m_age < 0) nage = (m_q > 0) ? 0 : -1;
      else if (m_age == 0) nage = 1;
      else if (d) begin
        ntot++; nage = -1; ncool = 1;
      end
`ifdef START_SEQ_TIMEOUT_EN
      else if (m_age == TO) begin
        tmo = 1; nage = -1; ncool = 1;
      end
`endif
      else nage = m_age + 1;
`ifdef START_SEQ_TIMEOUT_EN
      if (tmo) nerr = 1;
      else if (c) nerr = 0;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    m_q = nq; m_age = nage; m_cool = ncool;
    m_tot = ntot; m_err = nerr;
    chk("pending", int'(pending), m_q);
    chk("start", int'(start), int'(m_age == 0));
    chk("busy", int'(busy), int'((m_age >= 0) || m_cool));
    chk("req_ready", int'(req_ready), int'(m_q < DEPTH));
    chk("done_cnt", int'(done_cnt), m_tot % 256);
    chk("timeout_err", int'(timeout_err), int'(m_err));
  endtask

  initial begin
    int ns;
    int acc_n;
    int last_s;
    int dnext;
    // inputs v,d,c,r -> expected pending,start,busy,done_cnt
    tbl[0] = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 1, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
      chk("tbl_pending", int'(pending), tbl[i].p);
      chk("tbl_start", int'(start), int'(tbl[i].s));
      chk("tbl_busy", int'(busy), int'(tbl[i].b));
      chk("tbl_done_cnt", int'(done_cnt), tbl[i].dc);
    end

    // Single job, done 10 cycles after start
    step(0, 0, 0, 1);
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, i == 12, 0, 0);
      if (start) begin
        ns++;
        chk("single_start_cycle", i + 1, 2);
      end
      if (i == 12) chk("single_busy_cool", int'(busy), 1);
      if (i == 13) chk("single_busy_low", int'(busy), 0);
    end
    chk("single_starts", ns, 1);
    chk("single_done_cnt", int'(done_cnt), 1);

    // Backpressure
    step(0, 0, 0, 1);
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      acc_n += int'(last_acc);
    end
    chk("bp_accepted", acc_n, 5);
    chk("bp_pending", int'(pending), 4);
    chk("bp_ready", int'(req_ready), 0);

    // Back-to-back jobs
    step(0, 0, 0, 1);
    ns = 0;
    last_s = -100;
    dnext = -1;
    for (int i = 0; i < 100; i++) begin
      step(i < 3, i == dnext, 0, 0);
      if (start) begin
        ns++;
        if (ns > 1) chk("b2b_gap_ge12", int'((i + 1 - last_s) >= 12), 1);
        last_s = i + 1;
        dnext = i + 11;
      end
    end
    chk("b2b_starts", ns, 3);
    chk("b2b_done_cnt", int'(done_cnt), 3);
    chk("b2b_pending", int'(pending), 0);

`ifdef START_SEQ_TIMEOUT_EN
    // Watchdog: two jobs, done never returned
    step(0, 0, 0, 1);
    ns = 0;
    for (int i = 0; i < 46; i++) begin
      step(i < 2, 0, (i == 37) || (i == 38), 0);
      if (start) ns++;
      if (i == 17) chk("to_not_yet", int'(timeout_err), 0);
      if (i == 18) begin
        chk("to_set", int'(timeout_err), 1);
        chk("to_done_cnt", int'(done_cnt), 0);
      end
      if (i == 37) chk("to_set_beats_clr", int'(timeout_err), 1);
      if (i == 38) chk("to_cleared", int'(timeout_err), 0);
    end
    chk("to_starts", ns, 2);
`endif

    // Stray done, then reset in WAIT with pending=2
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("stray_done_cnt", int'(done_cnt), 0);
    chk("stray_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("mid_pending", int'(pending), 2);
    chk("mid_busy", int'(busy), 1);
    step(1, 1, 1, 1);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_done_cnt", int'(done_cnt), 0);
    ns = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0);
      if (start) ns++;
    end
    chk("rst_no_start", ns, 0);

    // Wrap after 256 completions
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000 && m_tot < 256; i++) step(1, 1, 0, 0);
    chk("wrap_reached", int'(m_tot >= 256), 1);
    chk("wrap_done_cnt", int'(done_cnt), 0);

    // Random traffic against the model
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(1, 0) == 1,
           $urandom_range(3, 0) == 0,
           $urandom_range(9, 0) == 0,
           $urandom_range(99, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the maximum number of queued job requests (1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles in WAIT before abort (2..255).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  meaning a job request is offered.
REQ-006 The block SHALL have port req_ready  output  1  meaning a request can be accepted this cycle.
REQ-007 The block SHALL have port start  output  1  meaning a one-cycle launch pulse to the downstream counter FSM.
REQ-008 The block SHALL have port done  input  1  meaning the completion pulse returned by the downstream counter FSM.
REQ-009 The block SHALL have port err_clr  input  1  meaning clear the sticky timeout flag.
REQ-010 The block SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-011 The block SHALL have port pending  output  4  meaning the number of queued, not-yet-launched jobs.
REQ-012 The block SHALL have port done_cnt  output  8  meaning the number of jobs completed.
REQ-013 The block SHALL have port timeout_err  output  1  meaning the sticky flag for an aborted job.

Function
REQ-014 Acceptance SHALL occur in a cycle where req_valid=1 and req_ready=1; req_ready SHALL be combinational (pending < DEPTH).
REQ-015 The FSM states SHALL be IDLE, ISSUE, WAIT and COOL.
REQ-016 In IDLE, the FSM SHALL move to ISSUE at the next edge when registered pending > 0, and otherwise stay in IDLE.
REQ-017 In ISSUE, the FSM SHALL move to WAIT unconditionally, and pending SHALL decrement by 1 at that same edge.
REQ-018 In WAIT, the FSM SHALL move to COOL on done=1, and done_cnt SHALL increment by 1, wrapping 255->0.
REQ-019 COOL SHALL last exactly one cycle and then return to IDLE, so the downstream FSM can return to its idle state before the next start.
REQ-020 start SHALL equal 1 exactly while the state is ISSUE, giving one cycle per job, and SHALL never be high in two consecutive cycles.
REQ-021 Latency: for a request accepted in cycle k with the FSM idle and pending=0, pending SHALL be 1 in cycle k+1 and start SHALL be high in cycle k+2.
REQ-022 On simultaneous acceptance and ISSUE decrement in the same cycle, pending SHALL be unchanged.
REQ-023 pending SHALL never exceed DEPTH and never underflow.
REQ-024 When pending equals DEPTH, req_ready SHALL be 0 and req_valid SHALL be ignored.
REQ-025 A done pulse outside WAIT SHALL be ignored, with no effect on state or done_cnt.
REQ-026 err_clr SHALL clear timeout_err at the next edge; a timeout set in the same cycle SHALL take priority, leaving timeout_err at 1.

Reset
REQ-027 When rst=1 at a clock edge, state SHALL become IDLE, pending 0, done_cnt 0, timeout_err 0 and the timeout counter 0.
REQ-028 Consequently start=0, busy=0 and req_ready=1 in the cycle after reset.
REQ-029 Reset asserted mid-job, in any state, SHALL discard all queued jobs with no further start pulse.
REQ-030 rst SHALL have priority over req_valid, done and err_clr.

Configuration
REQ-031 The macro START_SEQ_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-032 When START_SEQ_TIMEOUT_EN is defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without done.
REQ-033 When START_SEQ_TIMEOUT_EN is defined and the watchdog counter reaches TIMEOUT, the FSM SHALL go to COOL, set timeout_err=1 and leave done_cnt unchanged, and that job is dropped.
REQ-034 When START_SEQ_TIMEOUT_EN is undefined, WAIT SHALL persist until done, timeout_err SHALL be constant 0, err_clr SHALL be unused, and no watchdog counter SHALL exist.

Verification
REQ-035 Single job: reset, then a 1-cycle req_valid in cycle 0 and done pulsed 10 cycles after start -> start high only in cycle 2, done_cnt=1, busy low 2 cycles after done.
REQ-036 Backpressure with DEPTH=4: hold req_valid for 8 cycles while done is held 0 -> exactly 5 requests accepted (1 launched, 4 queued), pending=4, req_ready=0.
REQ-037 Back-to-back jobs: queue 3 jobs with done returned 10 cycles after each start -> 3 start pulses each separated by at least 12 cycles, done_cnt=3, pending=0.
REQ-038 Timeout (macro defined, TIMEOUT=16): one job with done never asserted -> timeout_err=1 after 16 WAIT cycles, done_cnt=0, and the next queued job still launches; err_clr then clears the flag.
REQ-039 Stray done plus reset: a done pulse in IDLE leaves done_cnt unchanged; then rst asserted in WAIT with pending=2 -> all outputs at reset values next cycle and no further start pulse.
REQ-040 Wrap: 256 completed jobs -> done_cnt=0.
